// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out serializer with valid/ready load handshake
module piso_serializer #(
   parameter int WIDTH     = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] pdata,
   output logic             dout,
   output logic             dout_valid,
   output logic             last,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CW-1:0]    cnt_q, cnt_d, cnt_inc, sel;
   logic             dout_d, valid_d, last_d;
   logic             accept;

   // Ready while idle, or in the cycle carrying the final bit so a new
   // word can follow with no gap; held low while reset is asserted.
   assign load_ready = rst_n & ((state_q == IDLE) | last);
   assign accept     = load_valid & load_ready;

   // The state register itself is the busy flag, so busy stays registered.
   assign busy = (state_q == SHIFT);

   // Next state and next registered outputs; cnt_q indexes the bit now on dout.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      dout_d  = 1'b0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      cnt_inc = cnt_q + CW'(1);
      sel     = (MSB_FIRST != 0) ? (CW'(WIDTH - 1) - cnt_inc) : cnt_inc;
      if (accept) begin
         state_d = SHIFT;
         data_d  = pdata;
         cnt_d   = '0;
         dout_d  = (MSB_FIRST != 0) ? pdata[WIDTH-1] : pdata[0];
         valid_d = 1'b1;
      end else if ((state_q == SHIFT) && !last) begin
         cnt_d   = cnt_inc;
         dout_d  = data_q[sel];
         valid_d = 1'b1;
         last_d  = (cnt_inc == CW'(WIDTH - 1));
      end else if (state_q == SHIFT) begin
         // Final bit went out and nothing new was offered.
         state_d = IDLE;
         cnt_d   = '0;
      end
   end

   // State, word and output registers; reset discards any word in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         data_q     <= '0;
         cnt_q      <= '0;
         dout       <= 1'b0;
         dout_valid <= 1'b0;
         last       <= 1'b0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         cnt_q      <= cnt_d;
         dout       <= dout_d;
         dout_valid <= valid_d;
         last       <= last_d;
      end
   end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 4: parallel word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 is sent first, 0 = bit 0 is sent first.
REQ-003 clk  input  1  single clock; all state updates on the posedge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 load_valid  input  1  upstream offers a word on pdata.
REQ-006 load_ready  output  1  block can accept a word this cycle.
REQ-007 pdata  input  WIDTH  parallel word; sampled only on an accept.
REQ-008 dout  output  1  serial data bit; drives the din of a downstream serial-in shift register.
REQ-009 dout_valid  output  1  dout carries a valid bit this cycle.
REQ-010 last  output  1  dout carries the final bit of the current word.
REQ-011 busy  output  1  a word is being shifted out.

Function
REQ-012 The block SHALL contain a two-state FSM: IDLE and SHIFT.
REQ-013 Accept SHALL be defined as load_valid AND load_ready sampled at a posedge.
REQ-014 load_ready SHALL be 1 in IDLE, 1 in SHIFT only during the last-bit cycle, and 0 otherwise.
REQ-015 On accept, the block SHALL capture pdata into an internal WIDTH-bit register, clear the bit counter and enter SHIFT.
REQ-016 On accept at edge E, the first bit SHALL appear on dout in the cycle after E: one cycle of latency.
REQ-017 dout, dout_valid, last and busy SHALL be registered outputs with no combinational path from inputs.
REQ-018 In SHIFT, dout_valid SHALL be 1 for exactly WIDTH consecutive cycles per word, one bit per cycle.
REQ-019 Bit order: MSB_FIRST=1 SHALL send bits WIDTH-1 down to 0; MSB_FIRST=0 SHALL send bits 0 up to WIDTH-1.
REQ-020 last SHALL be 1 only in the cycle carrying the WIDTH-th bit.
REQ-021 The bit counter SHALL be clog2(WIDTH) bits wide, count 0..WIDTH-1 and never wrap mid-word.
REQ-022 Back-to-back: an accept during the last-bit cycle SHALL make the next word's first bit follow with no gap cycle, and the FSM SHALL stay in SHIFT.
REQ-023 If the last-bit cycle has no accept, the FSM SHALL return to IDLE.
REQ-024 In IDLE, dout SHALL be 0, dout_valid SHALL be 0 and last SHALL be 0.
REQ-025 While load_ready=0, load_valid and pdata SHALL be ignored: the word in flight is unaffected, and changes to pdata after an accept have no effect.
REQ-026 busy SHALL be 1 exactly when the FSM is in SHIFT.

Reset
REQ-027 While rst_n=0, the FSM SHALL be in IDLE and the counter and data register SHALL be 0.
REQ-028 While rst_n=0, dout, dout_valid, last and busy SHALL be 0, and load_ready SHALL be 0.
REQ-029 Reset assertion SHALL take effect immediately, without waiting for clk, including mid-word.
REQ-030 After a mid-word reset, the partial word SHALL be discarded and never resumed.
REQ-031 load_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification
REQ-032 WIDTH=4, MSB_FIRST=1: accept pdata=4'b1011 at edge E -> dout=1,0,1,1 in cycles E+1..E+4; dout_valid=1 in those cycles only; last=1 in cycle E+4; busy falls after E+4.
REQ-033 Back-to-back: 4'b1011, then 4'b0110 accepted in the last-bit cycle -> dout=1,0,1,1,0,1,1,0 over 8 contiguous valid cycles; last=1 in cycles 4 and 8.
REQ-034 MSB_FIRST=0: pdata=4'b1011 -> dout=1,1,0,1; dout chained into a downstream 4-bit SISO shift register -> its q=4'b1011 after the edge that ends the last-bit cycle.
REQ-035 Hold load_valid=1 and toggle pdata every cycle during SHIFT -> serial output equals the originally accepted word; load_ready=0 until the last-bit cycle.
REQ-036 Reset mid-word: assert rst_n=0 after 2 bits of 4'b1011 -> all outputs 0 immediately without a clock edge; after release, accepting 4'b0001 -> dout=0,0,0,1 with no residual bits.
REQ-037 Idle gap: two words separated by 3 idle cycles -> dout=0 and dout_valid=0 throughout the gap, load_ready=1 throughout the gap.
